// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants and the active-low hex glyph table.
package sevenseg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // seg bit order is {g,f,e,d,c,b,a}, 0 = segment lit
   function automatic logic [6:0] hex2seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sevenseg_if.sv
// Bus between a display host (master) and the scanning driver (slave).
interface sevenseg_if #(parameter int DIGITS = 4);
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   dp;
   logic [DIGITS-1:0]   digit_en;
   logic                load;
   logic [6:0]          seg;
   logic                dp_n;
   logic [DIGITS-1:0]   an;

   modport master (output value, dp, digit_en, load, input seg, dp_n, an);
   modport slave  (input value, dp, digit_en, load, output seg, dp_n, an);
endinterface

// File: rtl/sevenseg_hex.sv
// Combinational hex nibble to active-low segment decoder.
module sevenseg_hex
   import sevenseg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   assign seg = hex2seg(nib);
endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner with shadowed display data.
// Define SEVENSEG_LZB_EN to blank leading-zero digits.
module sevenseg_scan
   import sevenseg_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int DIV    = 50000
) (
   input  logic      clk,
   input  logic      rst,
   sevenseg_if.slave bus
);
   localparam int CW = $clog2(DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
   localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

   logic [CW-1:0]            cnt;
   logic [IW-1:0]            idx;
   logic [DIGITS-1:0][3:0]   sh_val;
   logic [DIGITS-1:0]        sh_dp;
   logic [DIGITS-1:0]        sh_en;
   logic [3:0]               nib;
   logic [6:0]               hex_seg;
   logic                     lead_zero;

   assign nib = sh_val[idx];

   sevenseg_hex u_hex (.nib(nib), .seg(hex_seg));

`ifdef SEVENSEG_LZB_EN
   // lz[i]: every nibble from the top digit down to i is zero
   logic [DIGITS-1:0] lz;
   always_comb begin
      lz = '0;
      lz[DIGITS-1] = (sh_val[DIGITS-1] == 4'h0);
      for (int i = DIGITS - 2; i >= 0; i--)
         lz[i] = lz[i+1] & (sh_val[i] == 4'h0);
   end
   assign lead_zero = (idx != '0) && lz[idx];
`else
   assign lead_zero = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         idx      <= '0;
         sh_val   <= '0;
         sh_dp    <= '0;
         sh_en    <= '0;
         bus.seg  <= SEG_BLANK;
         bus.dp_n <= 1'b1;
         bus.an   <= '1;
      end else begin
         if (bus.load) begin
            sh_val <= bus.value;
            sh_dp  <= bus.dp;
            sh_en  <= bus.digit_en;
         end

         if (cnt == CMAX) begin
            cnt <= '0;
            idx <= (idx == IMAX) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end

         // first clock of every slot is dark so the previous digit cannot ghost
         if (cnt == '0) begin
            bus.seg  <= SEG_BLANK;
            bus.dp_n <= 1'b1;
            bus.an   <= '1;
         end else begin
            bus.seg  <= lead_zero ? SEG_BLANK : hex_seg;
            bus.dp_n <= ~sh_dp[idx];
            bus.an   <= sh_en[idx] ? ~(DIGITS'(1) << idx) : '1;
         end
      end
   end
endmodule

// File: tb/tb_sevenseg_scan.sv
// Randomised and directed bench for sevenseg_scan against a slot-arithmetic model.
module tb_sevenseg_scan;
   localparam int DIGITS = 4;
   localparam int DIV    = 4;

   logic clk = 1'b0;
   logic rst;

   sevenseg_if #(.DIGITS(DIGITS)) bus();

   sevenseg_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // model: edges since reset release plus the captured shadow contents
   int          pos;
   logic [15:0] m_val;
   logic [3:0]  m_dp;
   logic [3:0]  m_en;

   logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s pos=%0d obs=%h exp=%h", tag, pos, obs, exp);
      end
   endtask

   task automatic expect_out(output logic [6:0] s, output logic d, output logic [3:0] a);
      int c, ix;
      logic [15:0] upper;
      c  = pos % DIV;
      ix = (pos / DIV) % DIGITS;
      if (c == 0) begin
         s = 7'h7F; d = 1'b1; a = 4'hF;
      end else begin
         a = m_en[ix] ? ~(4'b0001 << ix) : 4'hF;
         d = ~m_dp[ix];
         s = hex_tbl[(m_val >> (4 * ix)) & 16'hF];
`ifdef SEVENSEG_LZB_EN
         upper = m_val >> (4 * ix);
         if (ix > 0 && upper == 16'h0) s = 7'h7F;
`else
         upper = 16'h0;
`endif
      end
   endtask

   task automatic tick();
      logic [6:0] es;
      logic       ed;
      logic [3:0] ea;
      @(posedge clk);
      expect_out(es, ed, ea);
      if (bus.load) begin
         m_val = bus.value;
         m_dp  = bus.dp;
         m_en  = bus.digit_en;
      end
      pos++;
      #1;
      chk("seg", {25'd0, bus.seg}, {25'd0, es});
      chk("dp_n", {31'd0, bus.dp_n}, {31'd0, ed});
      chk("an", {28'd0, bus.an}, {28'd0, ea});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      pos = 0; m_val = '0; m_dp = '0; m_en = '0;
      chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
      chk("rst_dp_n", {31'd0, bus.dp_n}, 32'h1);
      chk("rst_an", {28'd0, bus.an}, 32'hF);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic load_tick(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
      bus.value = v; bus.dp = d; bus.digit_en = e; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
   endtask

   initial begin
      int p, s, c;
      logic [3:0] an_tbl  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [6:0] seg_127 [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};

      bus.value = '0; bus.dp = '0; bus.digit_en = '0; bus.load = 1'b0;
      rst = 1'b1;
      #2;
      do_reset();

      // full scan of 12AF with every digit enabled
      load_tick(16'h12AF, 4'h0, 4'hF);
      for (int k = 0; k < 16; k++) begin
         tick();
         p = pos - 1; s = (p / DIV) % DIGITS; c = p % DIV;
         chk("scan_an", {28'd0, bus.an}, {28'd0, (c == 0) ? 4'hF : an_tbl[s]});
         chk("scan_seg", {25'd0, bus.seg}, {25'd0, (c == 0) ? 7'h7F : seg_127[s]});
      end

      // decimal point on digit 2 only
      load_tick(16'h12AF, 4'b0100, 4'hF);
      for (int k = 0; k < 16; k++) begin
         tick();
         p = pos - 1; s = (p / DIV) % DIGITS; c = p % DIV;
         chk("dp_slot", {31'd0, bus.dp_n}, (s == 2 && c != 0) ? 32'h0 : 32'h1);
      end

      // digit 2 disabled
      load_tick(16'h12AF, 4'h0, 4'b1011);
      for (int k = 0; k < 16; k++) begin
         tick();
         p = pos - 1; s = (p / DIV) % DIGITS; c = p % DIV;
         chk("en_an", {28'd0, bus.an}, {28'd0, (c == 0 || s == 2) ? 4'hF : an_tbl[s]});
      end

      // leading zeros
      load_tick(16'h0007, 4'h0, 4'hF);
      for (int k = 0; k < 16; k++) begin
         tick();
         p = pos - 1; s = (p / DIV) % DIGITS; c = p % DIV;
         if (c != 0) begin
`ifdef SEVENSEG_LZB_EN
            chk("lz_seg", {25'd0, bus.seg}, (s == 0) ? 32'h78 : 32'h7F);
`else
            chk("lz_seg", {25'd0, bus.seg}, (s == 0) ? 32'h78 : 32'h40);
`endif
         end
      end

      // inputs wander without load: display must hold
      for (int k = 0; k < 8; k++) begin
         bus.value = 16'($urandom); bus.dp = 4'($urandom); bus.digit_en = 4'($urandom);
         tick();
      end

      // load exactly on the slot-change clock
      while (pos % DIV != DIV - 1) tick();
      load_tick(16'h5C3E, 4'b0010, 4'hF);
      for (int k = 0; k < 8; k++) tick();

      // reset in the middle of slot 2
      while (pos % (DIV * DIGITS) != 2 * DIV + 2) tick();
      do_reset();
      load_tick(16'h1234, 4'h0, 4'hF);
      tick();
      chk("rst_resume_an", {28'd0, bus.an}, 32'hE);
      chk("rst_resume_seg", {25'd0, bus.seg}, 32'h19);

      // random traffic with occasional resets
      for (int k = 0; k < 400; k++) begin
         bus.value    = 16'($urandom);
         bus.dp       = 4'($urandom);
         bus.digit_en = 4'($urandom);
         bus.load     = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            tick();
         end
      end
      bus.load = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DIV, default 50000, clocks per digit slot (legal >= 2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port value  input  4*DIGITS  hex nibbles, nibble i = digit i (digit 0 rightmost).
REQ-006 SHALL have port dp  input  DIGITS  decimal point request per digit, active-high.
REQ-007 SHALL have port digit_en  input  DIGITS  per-digit enable, active-high.
REQ-008 SHALL have port load  input  1  capture strobe for value/dp/digit_en.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 SHALL have port dp_n  output  1  decimal point, active-low, registered.
REQ-011 SHALL have port an  output  DIGITS  digit anodes, active-low, at most one low, registered.

Function
REQ-012 SHALL copy value, dp, digit_en into shadow registers on any clk edge with load=1; display uses only shadow registers.
REQ-013 SHALL run divider cnt 0..DIV-1; at cnt=DIV-1 cnt wraps to 0 and digit index idx advances.
REQ-014 SHALL wrap idx from DIGITS-1 to 0; DIGITS=1 keeps idx at 0.
REQ-015 SHALL register outputs from current idx/cnt/shadow: one clock latency.
REQ-016 SHALL drive an all-high and seg=7'h7F, dp_n=1 while cnt=0 (anti-ghost blanking clock each slot).
REQ-017 SHALL otherwise drive an[idx]=0, others 1, when shadow digit_en[idx]=1; all an high when 0.
REQ-018 SHALL decode nibble (active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E (hex of seg).
REQ-019 SHALL drive dp_n = ~shadow dp[idx] during non-blanked clocks.
REQ-020 SHALL, on load coinciding with slot change, show new shadow data from the next output update; no mixed digit in one slot beyond one clock.

Reset
REQ-021 SHALL on rst: cnt=0, idx=0, shadows=0, seg=7'h7F, dp_n=1, an all-high, asynchronously.
REQ-022 SHALL on rst deassertion resume at idx 0, cnt 0, first slot blanked per REQ-016; reset mid-slot aborts the slot.

Configuration
REQ-023 SHALL, with SEVENSEG_LZB_EN defined, blank digit i>0 (seg=7'h7F, dp_n per REQ-019, an still per REQ-017) when shadow nibbles DIGITS-1..i are all zero; digit 0 never blanked.
REQ-024 SHALL, without SEVENSEG_LZB_EN, display every enabled digit including leading zeros.

Structure
REQ-025 SHALL place SEG_BLANK (7'h7F) and the 16-entry decode table/function in shared package sevenseg_pkg.
REQ-026 SHALL instantiate one combinational sub-module sevenseg_hex (4-bit in, 7-bit active-low out) for decode; counters/shadows stay in sevenseg_scan.

Verification
REQ-027 SHALL test: DIGITS=4, DIV=4, load value=16'h12AF, all en -> an cycles 1110,1101,1011,0111; seg 0E,08,24,79; blanking clock between each slot.
REQ-028 SHALL test: rst asserted mid-slot idx=2 -> outputs 7F/1/1111 immediately; after release idx 0 after DIV clocks.
REQ-029 SHALL test: digit_en=4'b1011 -> slot 2 an stays 1111 for full slot, other slots normal.
REQ-030 SHALL test: value=16'h0007 with SEVENSEG_LZB_EN -> digits 3..1 seg 7F, digit 0 seg 78; without macro digits 3..1 seg 40.
REQ-031 SHALL test: dp=4'b0100 -> dp_n=0 only during slot 2 non-blank clocks.
REQ-032 SHALL test: value changed without load -> display unchanged; load on slot-change clock -> new data from next update.
